// File: rtl/big_core_pkg.sv
// Shared types and default 640x480 timing for the big_core raster timing generator.
package big_core_pkg;

  localparam int unsigned VGA_XW_MAX = 12;
  localparam int unsigned VGA_YW_MAX = 12;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  typedef enum logic [1:0] {VGA_IDLE, VGA_RUN, VGA_DRAIN} t_vga_state;

  // hs/vs are the active (polarity-free) sync flags; coordinates sized for the largest raster.
  typedef struct packed {
    logic [VGA_XW_MAX-1:0] x;
    logic [VGA_YW_MAX-1:0] y;
    logic                  de;
    logic                  hs;
    logic                  vs;
    logic                  ls;
    logic                  fs;
  } t_vga_pix;

  localparam t_vga_pix VGA_PIX_BLANK = '0;

endpackage

// File: rtl/big_core_vga_pix_pipe.sv
// Fixed-depth delay line of raster entries between fetch and display, with a one-clock
// "tail just loaded" flag used to shape single-clock pulses.
module big_core_vga_pix_pipe
  import big_core_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic     Clk,
  input  logic     i_clr,
  input  logic     i_shift,
  input  t_vga_pix i_head,
  output t_vga_pix o_tail,
  output logic     o_loaded
);

  t_vga_pix [DEPTH-1:0] r_pipe;
  logic                 r_loaded;

  if (DEPTH == 1) begin : g_single
    always_ff @(posedge Clk) begin
      if (i_clr) begin
        r_pipe <= '0;
      end else if (i_shift) begin
        r_pipe[0] <= i_head;
      end
    end
  end else begin : g_multi
    always_ff @(posedge Clk) begin
      if (i_clr) begin
        r_pipe <= '0;
      end else if (i_shift) begin
        r_pipe <= {r_pipe[DEPTH-2:0], i_head};
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (i_clr) begin
      r_loaded <= 1'b0;
    end else begin
      r_loaded <= i_shift;
    end
  end

  assign o_tail   = r_pipe[DEPTH-1];
  assign o_loaded = r_loaded;

endmodule

// File: rtl/big_core_vga_timing_gen.sv
// Programmable raster timing generator: fetch coordinates lead the displayed pixel by LEAD
// pixel ticks; start/stop only on whole-frame boundaries.
module big_core_vga_timing_gen
  import big_core_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned CLK_DIV  = 1,
  parameter int unsigned LEAD     = 2,
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned XW      = $clog2(H_TOTAL),
  localparam int unsigned YW      = $clog2(V_TOTAL)
) (
  input  logic          Clk,
  input  logic          Rst_N,
  input  logic          En,
  output logic [XW-1:0] fetch_x,
  output logic [YW-1:0] fetch_y,
  output logic          fetch_valid,
  output logic [XW-1:0] CounterX,
  output logic [YW-1:0] CounterY,
  output logic          inDisplayArea,
  output logic          vga_h_sync,
  output logic          vga_v_sync,
  output logic          line_start,
  output logic          frame_start,
  output logic [15:0]   frame_cnt,
  output logic          busy
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned LW = $clog2(LEAD + 1);

  t_vga_state    r_state, w_state_nxt;
  logic [DW-1:0] r_div;
  logic [XW-1:0] r_fx;
  logic [YW-1:0] r_fy;
  logic [LW-1:0] r_drain;
  logic          r_stop_pend;
  logic [15:0]   r_frame_cnt;
  logic          w_run, w_tick, w_last, w_stop, w_drain_done;
  logic          w_de_f, w_hs_f, w_vs_f;
  logic          w_loaded, w_unused_tail;
  t_vga_pix      w_head, w_tail;

  assign w_run        = (r_state == VGA_RUN);
  assign w_tick       = (r_state != VGA_IDLE) && (32'(r_div) == CLK_DIV - 1);
  assign w_last       = (32'(r_fx) == H_TOTAL - 1) && (32'(r_fy) == V_TOTAL - 1);
  assign w_stop       = r_stop_pend || !En;
  assign w_drain_done = (32'(r_drain) == LEAD - 1);

  assign w_de_f = (32'(r_fx) < H_ACTIVE) && (32'(r_fy) < V_ACTIVE);
  assign w_hs_f = (32'(r_fx) >= H_ACTIVE + H_FP) && (32'(r_fx) < H_ACTIVE + H_FP + H_SYNC);
  assign w_vs_f = (32'(r_fy) >= V_ACTIVE + V_FP) && (32'(r_fy) < V_ACTIVE + V_FP + V_SYNC);

  always_ff @(posedge Clk) begin
    if (!Rst_N) begin
      r_state <= VGA_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      VGA_IDLE:  if (En) w_state_nxt = VGA_RUN;
      VGA_RUN:   if (w_tick && w_last && w_stop) w_state_nxt = VGA_DRAIN;
      VGA_DRAIN: if (w_tick && w_drain_done) w_state_nxt = VGA_IDLE;
      default:   w_state_nxt = VGA_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_N) begin
      r_div       <= '0;
      r_fx        <= '0;
      r_fy        <= '0;
      r_drain     <= '0;
      r_stop_pend <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_div <= (r_state == VGA_IDLE || w_tick) ? '0 : r_div + 1'b1;
      // Any clock of En low in RUN arms the stop; a later clock with En high disarms it.
      r_stop_pend <= w_run && !En;
      if (w_run && w_tick) begin
        if (32'(r_fx) == H_TOTAL - 1) begin
          r_fx <= '0;
          r_fy <= (32'(r_fy) == V_TOTAL - 1) ? '0 : r_fy + 1'b1;
        end else begin
          r_fx <= r_fx + 1'b1;
        end
      end
      if (r_state != VGA_DRAIN) begin
        r_drain <= '0;
      end else if (w_tick) begin
        r_drain <= r_drain + 1'b1;
      end
      if (frame_start) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_head = VGA_PIX_BLANK;
    if (w_run) begin
      w_head.x  = VGA_XW_MAX'(r_fx);
      w_head.y  = VGA_YW_MAX'(r_fy);
      w_head.de = w_de_f;
      w_head.hs = w_hs_f;
      w_head.vs = w_vs_f;
      w_head.ls = (r_fx == '0);
      w_head.fs = (r_fx == '0) && (r_fy == '0);
    end
  end

  big_core_vga_pix_pipe #(
    .DEPTH (LEAD)
  ) u_pix_pipe (
    .Clk      (Clk),
    .i_clr    (!Rst_N),
    .i_shift  (w_tick),
    .i_head   (w_head),
    .o_tail   (w_tail),
    .o_loaded (w_loaded)
  );

  assign w_unused_tail = ^{w_tail.x, w_tail.y};

  assign fetch_x       = r_fx;
  assign fetch_y       = r_fy;
  assign fetch_valid   = w_de_f && w_tick && w_run;
  assign CounterX      = w_tail.x[XW-1:0];
  assign CounterY      = w_tail.y[YW-1:0];
  assign inDisplayArea = w_tail.de;
  assign vga_h_sync    = H_POL ? w_tail.hs : ~w_tail.hs;
  assign vga_v_sync    = V_POL ? w_tail.vs : ~w_tail.vs;
  assign line_start    = w_tail.ls && w_loaded;
  assign frame_start   = w_tail.fs && w_loaded;
  assign frame_cnt     = r_frame_cnt;
  assign busy          = (r_state != VGA_IDLE);

endmodule

// File: tb/tb_big_core_vga_timing_gen.sv
// Bench for the raster timing generator on an 8x6 raster; four instances cover
// CLK_DIV 1/3 and LEAD 1/2/7.
module tb_big_core_vga_timing_gen;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int NDUT = 4;

  typedef struct packed {
    logic [2:0] x;
    logic [2:0] y;
    logic       de;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
  } pix_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en          [NDUT];
  logic [2:0] fetch_x     [NDUT];
  logic [2:0] fetch_y     [NDUT];
  logic [2:0] cnt_x       [NDUT];
  logic [2:0] cnt_y       [NDUT];
  logic       fetch_valid [NDUT];
  logic       de          [NDUT];
  logic       hsync       [NDUT];
  logic       vsync       [NDUT];
  logic       ls          [NDUT];
  logic       fs          [NDUT];
  logic       busy        [NDUT];
  logic [15:0] frame_cnt  [NDUT];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    big_core_vga_timing_gen #(
      .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
      .H_POL    (1'b0), .V_POL (1'b0),
      .CLK_DIV  ((g == 1) ? 3 : 1),
      .LEAD     ((g == 2) ? 1 : ((g == 3) ? 7 : 2))
    ) u_dut (
      .Clk           (clk),
      .Rst_N         (rst_n),
      .En            (en[g]),
      .fetch_x       (fetch_x[g]),
      .fetch_y       (fetch_y[g]),
      .fetch_valid   (fetch_valid[g]),
      .CounterX      (cnt_x[g]),
      .CounterY      (cnt_y[g]),
      .inDisplayArea (de[g]),
      .vga_h_sync    (hsync[g]),
      .vga_v_sync    (vsync[g]),
      .line_start    (ls[g]),
      .frame_start   (fs[g]),
      .frame_cnt     (frame_cnt[g]),
      .busy          (busy[g])
    );
  end

  // Expected displayed entry for raster position (x,y); sync fields hold the pin level.
  function automatic pix_t model(input int x, input int y);
    pix_t p;
    p.x  = 3'(x);
    p.y  = 3'(y);
    p.de = (x < HA) && (y < VA);
    p.hs = !((x >= HA + HF) && (x < HA + HF + HS));
    p.vs = !((y >= VA + VF) && (y < VA + VF + VS));
    p.ls = (x == 0);
    p.fs = (x == 0) && (y == 0);
    return p;
  endfunction

  function automatic pix_t blank();
    pix_t p;
    p    = '0;
    p.hs = 1'b1;
    p.vs = 1'b1;
    return p;
  endfunction

  function automatic pix_t disp(input int g);
    pix_t p;
    p = {cnt_x[g], cnt_y[g], de[g], hsync[g], vsync[g], ls[g], fs[g]};
    return p;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    for (int g = 0; g < NDUT; g++) en[g] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      n_tests++;
      if ({fetch_x[g], fetch_y[g], fetch_valid[g], disp(g), frame_cnt[g], busy[g]} !==
          {3'd0, 3'd0, 1'b0, blank(), 16'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset g%0d fetch=(%0d,%0d) fv=%b disp=%h fc=%0d busy=%b, required idle/blank",
                 g, fetch_x[g], fetch_y[g], fetch_valid[g], disp(g), frame_cnt[g], busy[g]);
      end
    end
  endtask

  // Scoreboard run on a CLK_DIV=1 instance: fetch entries are queued and popped LEAD ticks later.
  task automatic test_lead(input int g, input int lead, input int drop_at);
    pix_t q[$];
    pix_t e;
    int mx = 0, my = 0, mst = 1, dcnt = 0, fc = 0, c = 0;
    for (int i = 0; i < lead; i++) q.push_back(blank());
    en[g] = 1'b1;
    while (mst != 0 && c < drop_at + 200) begin
      @(negedge clk);
      n_tests++;
      if ({fetch_x[g], fetch_y[g], fetch_valid[g], busy[g]} !==
          {3'(mx), 3'(my), (mst == 1) && model(mx, my).de, 1'b1}) begin
        n_fail++;
        $display("FAIL lead_fetch g%0d c%0d got (%0d,%0d) fv=%b busy=%b, required (%0d,%0d) st=%0d",
                 g, c, fetch_x[g], fetch_y[g], fetch_valid[g], busy[g], mx, my, mst);
      end
      q.push_back((mst == 1) ? model(mx, my) : blank());
      e = q.pop_front();
      n_tests++;
      if (disp(g) !== e) begin
        n_fail++;
        $display("FAIL lead_disp g%0d c%0d got %h required %h", g, c, disp(g), e);
      end
      n_tests++;
      if (frame_cnt[g] !== 16'(fc)) begin
        n_fail++;
        $display("FAIL lead_fcnt g%0d c%0d got %0d required %0d", g, c, frame_cnt[g], fc);
      end
      if (e.fs) fc++;
      if (mst == 1) begin
        if (mx == HT - 1 && my == VT - 1 && !en[g]) begin
          mst  = 2;
          dcnt = lead;
        end
        if (mx == HT - 1) begin
          mx = 0;
          my = (my == VT - 1) ? 0 : my + 1;
        end else begin
          mx++;
        end
      end else begin
        dcnt--;
        if (dcnt == 0) mst = 0;
      end
      c++;
      if (c == drop_at) en[g] = 1'b0;
    end
    @(negedge clk);
    n_tests++;
    if (mst != 0 || {busy[g], fetch_x[g], fetch_y[g], fetch_valid[g], disp(g), frame_cnt[g]} !==
        {1'b0, 3'd0, 3'd0, 1'b0, blank(), 16'(fc)}) begin
      n_fail++;
      $display("FAIL lead_idle g%0d busy=%b fetch=(%0d,%0d) disp=%h fc=%0d, required idle fc=%0d",
               g, busy[g], fetch_x[g], fetch_y[g], disp(g), frame_cnt[g], fc);
    end
  endtask

  task automatic test_sync_de();
    int k = 0, n_de = 0, n_hs = 0, n_vs = 0, n_ls = 0, n_fs = 0, n_bad = 0;
    en[0] = 1'b1;
    while (!fs[0] && k < 20) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < HT * VT; i++) begin
      n_de += int'(de[0]);
      n_hs += int'(!hsync[0]);
      n_vs += int'(!vsync[0]);
      n_ls += int'(ls[0]);
      n_fs += int'(fs[0]);
      if (disp(0) !== model(int'(cnt_x[0]), int'(cnt_y[0]))) n_bad++;
      @(negedge clk);
    end
    n_tests++;
    if ({n_de, n_hs, n_vs, n_ls, n_fs, n_bad} !== {32'd12, 32'd12, 32'd8, 32'd6, 32'd1, 32'd0}) begin
      n_fail++;
      $display("FAIL sync_de de=%0d hs_low=%0d vs_low=%0d ls=%0d fs=%0d bad=%0d, required 12 12 8 6 1 0",
               n_de, n_hs, n_vs, n_ls, n_fs, n_bad);
    end
    en[0] = 1'b0;
    k = 0;
    while (busy[0] && k < 120) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL sync_de_stop busy=%b required 0", busy[0]);
    end
  endtask

  task automatic test_clkdiv();
    int k = 0, t = 0, t_chg = -1, t_fs = -1;
    logic [2:0] px;
    logic pls;
    pix_t pd;
    en[1] = 1'b1;
    while (!fs[1] && k < 30) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (fs[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL clkdiv_start fs=%b required 1", fs[1]);
    end
    px = cnt_x[1]; pls = ls[1]; pd = disp(1); t_fs = 0; t_chg = 0;
    for (t = 1; t < 320; t++) begin
      @(negedge clk);
      if (cnt_x[1] !== px) begin
        n_tests++;
        if (t - t_chg != 3) begin
          n_fail++;
          $display("FAIL clkdiv_period t%0d got %0d clocks required 3", t, t - t_chg);
        end
        t_chg = t;
      end else begin
        n_tests++;
        if ({disp(1).y, disp(1).de, disp(1).hs, disp(1).vs, disp(1).ls, disp(1).fs} !==
            {pd.y, pd.de, pd.hs, pd.vs, 2'b00}) begin
          n_fail++;
          $display("FAIL clkdiv_hold t%0d got %h required %h without pulses", t, disp(1), pd);
        end
      end
      if (pls && ls[1]) begin
        n_tests++;
        n_fail++;
        $display("FAIL clkdiv_ls_width t%0d got 2 clocks required 1", t);
      end
      if (fs[1]) begin
        n_tests++;
        if (t - t_fs != 144) begin
          n_fail++;
          $display("FAIL clkdiv_frame t%0d got %0d clocks required 144", t, t - t_fs);
        end
        t_fs = t;
      end
      px = cnt_x[1]; pls = ls[1]; pd = disp(1);
    end
    en[1] = 1'b0;
    k = 0;
    while (busy[1] && k < 400) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (busy[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL clkdiv_stop busy=%b required 0", busy[1]);
    end
  endtask

  task automatic test_restart();
    int k = 0;
    en[0] = 1'b1;
    while (!(fetch_x[0] == 3'd2 && fetch_y[0] == 3'd1 && busy[0]) && k < 60) begin
      @(negedge clk);
      k++;
    end
    en[0] = 1'b0;
    repeat (5) @(negedge clk);
    en[0] = 1'b1;
    k = 0;
    while (!(fetch_x[0] == 3'd7 && fetch_y[0] == 3'd5) && k < 60) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    n_tests++;
    if ({busy[0], fetch_x[0], fetch_y[0], fetch_valid[0]} !== {1'b1, 3'd0, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL restart_nostop busy=%b fetch=(%0d,%0d) fv=%b, required 1 (0,0) 1",
               busy[0], fetch_x[0], fetch_y[0], fetch_valid[0]);
    end
    en[0] = 1'b0;
    k = 0;
    while (!(fetch_x[0] == 3'd7 && fetch_y[0] == 3'd5) && k < 60) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    n_tests++;
    if ({busy[0], fetch_valid[0]} !== 2'b10) begin
      n_fail++;
      $display("FAIL restart_drain1 busy=%b fv=%b required 1 0", busy[0], fetch_valid[0]);
    end
    en[0] = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({busy[0], fetch_valid[0]} !== 2'b10) begin
      n_fail++;
      $display("FAIL restart_drain2 busy=%b fv=%b required 1 0", busy[0], fetch_valid[0]);
    end
    @(negedge clk);
    n_tests++;
    if ({busy[0], disp(0)} !== {1'b0, blank()}) begin
      n_fail++;
      $display("FAIL restart_idle busy=%b disp=%h required 0 %h", busy[0], disp(0), blank());
    end
    @(negedge clk);
    n_tests++;
    if ({busy[0], fetch_x[0], fetch_y[0], fetch_valid[0]} !== {1'b1, 3'd0, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL restart_run busy=%b fetch=(%0d,%0d) fv=%b required 1 (0,0) 1",
               busy[0], fetch_x[0], fetch_y[0], fetch_valid[0]);
    end
    en[0] = 1'b0;
    k = 0;
    while (busy[0] && k < 120) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    en[0] = 1'b1;
    while (!(fetch_x[0] == 3'd3 && fetch_y[0] == 3'd2 && busy[0]) && k < 60) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (frame_cnt[0] == 16'd0) begin
      n_fail++;
      $display("FAIL reset_mid_pre frame_cnt got 0 required nonzero");
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({fetch_x[0], fetch_y[0], fetch_valid[0], disp(0), frame_cnt[0], busy[0]} !==
        {3'd0, 3'd0, 1'b0, blank(), 16'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid fetch=(%0d,%0d) fv=%b disp=%h fc=%0d busy=%b, required idle/blank",
               fetch_x[0], fetch_y[0], fetch_valid[0], disp(0), frame_cnt[0], busy[0]);
    end
    en[0] = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({busy[0], disp(0)} !== {1'b0, blank()}) begin
      n_fail++;
      $display("FAIL reset_mid_after busy=%b disp=%h required 0 %h", busy[0], disp(0), blank());
    end
  endtask

  initial begin
    test_reset();
    test_lead(0, 2, 154);
    test_sync_de();
    test_clkdiv();
    test_restart();
    test_lead(2, 1, 40);
    test_lead(3, 7, 70);
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
